saed32_64x32_port_arbiter: RTL and testbench

//  Shares the two ports of the SAED32 64x32 dual-port SRAM wrapper between NREQ requesters.

---
 rtl/saed32_64x32_port_arbiter_pkg.sv | 45 ++++
 rtl/saed32_64x32_port_arbiter_rr_find_next.sv | 29 ++
 rtl/saed32_64x32_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_saed32_64x32_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/saed32_64x32_port_arbiter_pkg.sv
// Shared types and helpers for the SAED32 64x32 dual-port SRAM port arbiter.
// Holds the wrapper port bundle, the read-response tag and index-width helpers.
package saed32_sram_pkg;

  localparam int SRAM_AW = 6;
  localparam int SRAM_DW = 32;
  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               ce;
    logic               we;
    logic [SRAM_AW-1:0] a;
    logic [SRAM_DW-1:0] d;
    logic [SRAM_DW-1:0] wem;
  } mem_port_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } rsp_tag_t;

  function automatic int idw_f(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // An idle port drives zeros; reads never carry a write mask.
  function automatic mem_port_t make_port(input logic               ce,
                                          input logic               we,
                                          input logic [SRAM_AW-1:0] a,
                                          input logic [SRAM_DW-1:0] d,
                                          input logic [SRAM_DW-1:0] wem);
    mem_port_t p;
    p.ce  = ce;
    p.we  = ce & we;
    p.a   = ce ? a : {SRAM_AW{1'b0}};
    p.d   = ce ? d : {SRAM_DW{1'b0}};
    p.wem = (ce && we) ? wem : {SRAM_DW{1'b0}};
    return p;
  endfunction

endpackage

// File: rtl/saed32_64x32_port_arbiter_rr_find_next.sv
// Round-robin search: first set bit of mask at or after start, wrapping at NREQ.
module rr_find_next
  import saed32_sram_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]           mask,
  input  logic [idw_f(NREQ)-1:0]    start,
  output logic                      found,
  output logic [idw_f(NREQ)-1:0]    idx
);

  localparam int IDW = idw_f(NREQ);

  // Scan from the farthest candidate back so the nearest one to start wins.
  always_comb begin
    found = 1'b0;
    idx   = {IDW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (mask[(int'(start) + k) % NREQ]) begin
        found = 1'b1;
        idx   = IDW'((int'(start) + k) % NREQ);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/saed32_64x32_port_arbiter.sv
// Round-robin arbiter sharing both ports of the SAED32 64x32 dual-port SRAM
// wrapper between NREQ requesters, with a one-cycle tagged read return path.
module saed32_64x32_port_arbiter
  import saed32_sram_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = SRAM_AW,
  parameter int DW   = SRAM_DW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*DW-1:0]   req_wmask,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 mem_ce0,
  output logic                 mem_ce1,
  output logic                 mem_we0,
  output logic                 mem_we1,
  output logic [AW-1:0]        mem_a0,
  output logic [AW-1:0]        mem_a1,
  output logic [DW-1:0]        mem_d0,
  output logic [DW-1:0]        mem_d1,
  output logic [DW-1:0]        mem_wem0,
  output logic [DW-1:0]        mem_wem1,
  input  logic [DW-1:0]        mem_q0,
  input  logic [DW-1:0]        mem_q1
);

  localparam int IDW = idw_f(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return {IDW{1'b0}};
    end else begin
      return i + IDW'(1'b1);
    end
  endfunction

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  g0_idx, g1_idx, g1_start;
  logic            g0_found, g1_found;
  logic [NREQ-1:0] g0_oh, g1_oh, g1_mask;
  logic            g0_we, g1_we, same_addr;
  logic [AW-1:0]   g0_addr, g1_addr;
  logic            grant0, grant1;
  mem_port_t       port0, port1;
  rsp_tag_t        tag0_d, tag0_q, tag1_d, tag1_q;
  logic [NREQ-1:0] tag0_oh, tag1_oh;

  rr_find_next #(.NREQ(NREQ)) u_find_g0 (
    .mask  (req_valid),
    .start (rr_ptr_q),
    .found (g0_found),
    .idx   (g0_idx)
  );

  rr_find_next #(.NREQ(NREQ)) u_find_g1 (
    .mask  (g1_mask),
    .start (g1_start),
    .found (g1_found),
    .idx   (g1_idx)
  );

  // Grant selection, port bundles, response tags and pointer advance.
  always_comb begin
    g0_oh     = ONE_HOT0 << g0_idx;
    g1_oh     = ONE_HOT0 << g1_idx;
    g1_mask   = req_valid & ~g0_oh;
    g1_start  = wrap_inc(g0_idx);
    g0_we     = req_we[g0_idx];
    g1_we     = req_we[g1_idx];
    g0_addr   = req_addr[int'(g0_idx)*AW +: AW];
    g1_addr   = req_addr[int'(g1_idx)*AW +: AW];
    same_addr = (g0_addr == g1_addr);

    grant0 = !RST && g0_found;
    // Port 1 needs a write on at least one side (single read-return bus) and no address overlap.
    grant1 = grant0 && g1_found && (g0_we || g1_we) && !same_addr;

    port0 = make_port(grant0, g0_we, g0_addr,
                      req_wdata[int'(g0_idx)*DW +: DW], req_wmask[int'(g0_idx)*DW +: DW]);
    port1 = make_port(grant1, g1_we, g1_addr,
                      req_wdata[int'(g1_idx)*DW +: DW], req_wmask[int'(g1_idx)*DW +: DW]);

    req_ready = (grant0 ? g0_oh : {NREQ{1'b0}}) | (grant1 ? g1_oh : {NREQ{1'b0}});

    tag0_d              = {1'b0, {TAG_IDW{1'b0}}};
    tag0_d.valid        = grant0 && !g0_we;
    tag0_d.id[IDW-1:0]  = g0_idx;
    tag1_d              = {1'b0, {TAG_IDW{1'b0}}};
    tag1_d.valid        = grant1 && !g1_we;
    tag1_d.id[IDW-1:0]  = g1_idx;

    if (grant1) begin
      rr_ptr_d = wrap_inc(g1_idx);
    end else if (grant0) begin
      rr_ptr_d = wrap_inc(g0_idx);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer and per-port read tags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q <= {IDW{1'b0}};
      tag0_q   <= {1'b0, {TAG_IDW{1'b0}}};
      tag1_q   <= {1'b0, {TAG_IDW{1'b0}}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
    end
  end

  // Read return: port 0 owns the shared data bus whenever it has data.
  always_comb begin
    tag0_oh   = tag0_q.valid ? (ONE_HOT0 << tag0_q.id) : {NREQ{1'b0}};
    tag1_oh   = tag1_q.valid ? (ONE_HOT0 << tag1_q.id) : {NREQ{1'b0}};
    rsp_valid = RST ? {NREQ{1'b0}} : (tag0_oh | tag1_oh);
    if (tag0_q.valid) begin
      rsp_rdata = mem_q0;
    end else if (tag1_q.valid) begin
      rsp_rdata = mem_q1;
    end else begin
      rsp_rdata = {DW{1'b0}};
    end
  end

  assign mem_ce0  = port0.ce;
  assign mem_we0  = port0.we;
  assign mem_a0   = port0.a;
  assign mem_d0   = port0.d;
  assign mem_wem0 = port0.wem;
  assign mem_ce1  = port1.ce;
  assign mem_we1  = port1.we;
  assign mem_a1   = port1.a;
  assign mem_d1   = port1.d;
  assign mem_wem1 = port1.wem;

endmodule

// File: tb/tb_saed32_64x32_port_arbiter.sv
// Scoreboard bench for saed32_64x32_port_arbiter with a behavioural dual-port SRAM
// model; expected read data comes from a reference memory updated on acceptance.
module tb_saed32_64x32_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam logic [DW-1:0] ONES = 32'hFFFF_FFFF;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata, req_wmask;
  logic [DW-1:0]       rsp_rdata;
  logic                mem_ce0, mem_ce1, mem_we0, mem_we1;
  logic [AW-1:0]       mem_a0, mem_a1;
  logic [DW-1:0]       mem_d0, mem_d1, mem_wem0, mem_wem1;
  logic [DW-1:0]       mem_q0, mem_q1;

  logic [DW-1:0] sram    [64];
  logic [DW-1:0] ref_mem [64];
  exp_t          sb_q[$];
  int            n_total = 0;
  int            n_bad   = 0;

  always #5 CLK = ~CLK;

  saed32_64x32_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_ce0(mem_ce0), .mem_ce1(mem_ce1), .mem_we0(mem_we0), .mem_we1(mem_we1),
    .mem_a0(mem_a0), .mem_a1(mem_a1), .mem_d0(mem_d0), .mem_d1(mem_d1),
    .mem_wem0(mem_wem0), .mem_wem1(mem_wem1), .mem_q0(mem_q0), .mem_q1(mem_q1)
  );

  // SRAM wrapper model: bit-masked writes, one-cycle registered reads.
  always @(posedge CLK) begin
    if (mem_ce0 && mem_we0) sram[mem_a0] <= (sram[mem_a0] & ~mem_wem0) | (mem_d0 & mem_wem0);
    if (mem_ce0 && !mem_we0) mem_q0 <= sram[mem_a0];
    if (mem_ce1 && mem_we1) sram[mem_a1] <= (sram[mem_a1] & ~mem_wem1) | (mem_d1 & mem_wem1);
    if (mem_ce1 && !mem_we1) mem_q1 <= sram[mem_a1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_wmask[i*DW +: DW]  = m;
  endtask

  // Mid-cycle: check the pending response, check grants, then update the model.
  task automatic sample(input logic [NREQ-1:0] exp_rdy);
    exp_t          e;
    logic [AW-1:0] a;
    logic [DW-1:0] d, m;
    #3;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'd1 << e.id);
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
    end else begin
      chk("rsp_idle", 64'(rsp_valid), 64'd0);
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i]) begin
        a = req_addr[i*AW +: AW];
        d = req_wdata[i*DW +: DW];
        m = req_wmask[i*DW +: DW];
        if (req_we[i]) begin
          ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        end else begin
          e.id   = i;
          e.data = ref_mem[a];
          sb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    req_valid = {NREQ{1'b0}};
    #3;
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    sb_q.delete();
    advance();
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = {NREQ{1'b0}};
    req_we    = {NREQ{1'b0}};
    req_addr  = {(NREQ*AW){1'b0}};
    req_wdata = {(NREQ*DW){1'b0}};
    req_wmask = {(NREQ*DW){1'b0}};
    repeat (2) @(posedge CLK);
    #1;

    // Reset holds grants and enables low even with every requester valid.
    req_valid = {NREQ{1'b1}};
    #3;
    chk("t1_ready", 64'(req_ready), 64'd0);
    chk("t1_ce0", 64'(mem_ce0), 64'd0);
    chk("t1_ce1", 64'(mem_ce1), 64'd0);
    chk("t1_rsp", 64'(rsp_valid), 64'd0);
    advance();
    RST       = 1'b0;
    req_valid = {NREQ{1'b0}};

    // Lone requester 2: write then read back-to-back on port 0.
    set_req(2, 1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF, ONES);
    sample(4'b0100);
    chk("t2_ce0", 64'(mem_ce0), 64'd1);
    chk("t2_we0", 64'(mem_we0), 64'd1);
    chk("t2_a0", 64'(mem_a0), 64'd5);
    chk("t2_d0", 64'(mem_d0), 64'hDEAD_BEEF);
    chk("t2_ce1", 64'(mem_ce1), 64'd0);
    advance();
    set_req(2, 1'b1, 1'b0, 6'd5, 32'h0000_0000, ONES);
    sample(4'b0100);
    chk("t2_rd_we0", 64'(mem_we0), 64'd0);
    chk("t2_rd_wem0", 64'(mem_wem0), 64'd0);
    advance();
    req_valid = {NREQ{1'b0}};
    sample(4'b0000);
    chk("t2_data", 64'(rsp_rdata), 64'hDEAD_BEEF);
    advance();

    // All four writing distinct addresses from rr_ptr=0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 6'(10 + i), 32'hA000_0000 + i, ONES);
    sample(4'b0011);
    chk("t3_ce1", 64'(mem_ce1), 64'd1);
    chk("t3_a1", 64'(mem_a1), 64'd11);
    advance();
    sample(4'b1100);
    chk("t3_a0", 64'(mem_a0), 64'd12);
    chk("t3_a1b", 64'(mem_a1), 64'd13);
    advance();
    sample(4'b0011);
    advance();
    req_valid = {NREQ{1'b0}};

    // Write/read to the same address: the read waits one cycle.
    set_req(0, 1'b1, 1'b1, 6'd9, 32'h0909_5A5A, ONES);
    set_req(1, 1'b1, 1'b0, 6'd9, 32'h0000_0000, ONES);
    sample(4'b0001);
    chk("t4_ce1", 64'(mem_ce1), 64'd0);
    advance();
    req_valid[0] = 1'b0;
    sample(4'b0010);
    advance();
    req_valid = {NREQ{1'b0}};
    sample(4'b0000);
    advance();

    // Partial write mask merges with prior contents.
    set_req(3, 1'b1, 1'b1, 6'd3, 32'h1234_5678, ONES);
    sample(4'b1000);
    advance();
    set_req(3, 1'b1, 1'b1, 6'd3, 32'hFFFF_0000, 32'h0000_FFFF);
    sample(4'b1000);
    chk("t5_wem0", 64'(mem_wem0), 64'h0000_FFFF);
    advance();
    set_req(3, 1'b1, 1'b0, 6'd3, 32'h0000_0000, 32'h0000_0000);
    sample(4'b1000);
    advance();
    req_valid = {NREQ{1'b0}};
    sample(4'b0000);
    chk("t5_merge", 64'(rsp_rdata), 64'h1234_0000);
    advance();

    // Reset right after a read grant drops the response.
    set_req(1, 1'b1, 1'b0, 6'd10, 32'h0000_0000, 32'h0000_0000);
    sample(4'b0010);
    advance();
    do_reset();
    sample(4'b0000);
    advance();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 6'(20 + i), 32'hC000_0000 + i, ONES);
    sample(4'b0011);
    advance();

    // Two reads never share a cycle; port 1 serves a read next to a port 0 write.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 6'(20 + i), 32'h0000_0000, ONES);
    sample(4'b0100);
    advance();
    req_valid[2] = 1'b0;
    sample(4'b1000);
    advance();
    set_req(0, 1'b1, 1'b1, 6'd30, 32'h5555_AAAA, ONES);
    set_req(1, 1'b1, 1'b0, 6'd21, 32'h0000_0000, ONES);
    req_valid[3] = 1'b0;
    sample(4'b0011);
    chk("t7_we1", 64'(mem_we1), 64'd0);
    advance();
    req_valid = {NREQ{1'b0}};
    sample(4'b0000);
    advance();
    sample(4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
